// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
//   div_state_t : controller states (IDLE, RUN, DONE)
//   DEFAULT_N   : default operand width
package seq_div_pkg;

    localparam int DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/normal_sub_n_bit.sv
// Ripple-borrow subtractor diff = a - b, built as a + ~b + 1 from full_adder cells.
//   a, b   : W-bit minuend and subtrahend
//   diff   : W-bit difference (modulo 2^W)
//   borrow : 1 when b > a (the final carry is the inverse of the borrow)
module normal_sub_n_bit #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W:0] carry_s;

    assign carry_s[0] = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_cell
        full_adder u_fa (
            .a    (a[i]),
            .b    (~b[i]),
            .cin  (carry_s[i]),
            .sum  (diff[i]),
            .cout (carry_s[i+1])
        );
    end

    assign borrow = ~carry_s[W];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk, rst            : clock, synchronous active-high reset
//   start               : request, accepted only when not busy (IDLE or DONE)
//   dividend, divisor   : operands, sampled on the accepting edge
//   busy                : high for the N iteration cycles
//   done                : one-cycle pulse, results valid
//   quotient, remainder : results, updated only on entry to DONE
//   div_by_zero         : set with done when divisor was zero, held with results
module seq_restoring_divider
    import seq_div_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CNT_W = $clog2(N + 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N:0]       p_q, p_d;
    logic [N-1:0]     q_q, q_d;
    logic [N-1:0]     dvs_q, dvs_d;
    logic [N-1:0]     quot_q, quot_d;
    logic [N-1:0]     rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [N:0]       p_shift_s;
    logic [N:0]       trial_s;
    logic             borrow_s;
    logic [N:0]       p_next_s;
    logic [N-1:0]     q_next_s;

    // The dividend's MSB shifts into the partial remainder each iteration.
    assign p_shift_s = {p_q[N-1:0], q_q[N-1]};

    normal_sub_n_bit #(.W(N + 1)) u_sub (
        .a      (p_shift_s),
        .b      ({1'b0, dvs_q}),
        .diff   (trial_s),
        .borrow (borrow_s)
    );

    // Restore on borrow: keep the shifted remainder and record a 0 quotient bit.
    assign p_next_s = borrow_s ? p_shift_s : trial_s;
    assign q_next_s = {q_q[N-2:0], ~borrow_s};

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dvs_d = divisor;
                    q_d   = dividend;
                    p_d   = {(N + 1){1'b0}};
                    cnt_d = {CNT_W{1'b0}};
                    dbz_d = 1'b0;
                    if (divisor != {N{1'b0}}) begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end else begin
                        // Zero divisor skips iteration and reports saturated quotient.
                        state_d = DONE;
                        done_d  = 1'b1;
                        quot_d  = {N{1'b1}};
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                p_d   = p_next_s;
                q_d   = q_next_s;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    quot_d  = q_next_s;
                    rem_d   = p_next_s[N-1:0];
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            p_q     <= {(N + 1){1'b0}};
            q_q     <= {N{1'b0}};
            dvs_q   <= {N{1'b0}};
            quot_q  <= {N{1'b0}};
            rem_q   <= {N{1'b0}};
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    seq_restoring_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a division takes N busy cycles then a done cycle;
    // results come from plain / and %.
    int           m_left = 0;
    logic         m_done = 1'b0;
    logic [N-1:0] m_q    = '0;
    logic [N-1:0] m_r    = '0;
    logic         m_dbz  = 1'b0;
    logic [N-1:0] m_pq   = '0;
    logic [N-1:0] m_pr   = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            m_dbz  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_q    <= m_pq;
                    m_r    <= m_pr;
                end
            end else if (start) begin
                if (divisor == '0) begin
                    m_done <= 1'b1;
                    m_q    <= '1;
                    m_r    <= dividend;
                    m_dbz  <= 1'b1;
                end else begin
                    m_left <= N;
                    m_pq   <= dividend / divisor;
                    m_pr   <= dividend % divisor;
                    m_dbz  <= 1'b0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_busy", busy, (m_left != 0));
            check("model_done", done, m_done);
            check("model_quotient", quotient, m_q);
            check("model_remainder", remainder, m_r);
            check("model_div_by_zero", div_by_zero, m_dbz);
        end
    end

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts cycles after the accepting edge until done; -1 on timeout.
    task automatic wait_done(output int lat, output bit saw_busy);
        lat      = 0;
        saw_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (busy) saw_busy = 1'b1;
            if (done) return;
        end
        lat = -1;
    endtask

    int lat;
    bit sb;
    int n_dones;
    logic [N-1:0] tv_a [4] = '{8'd255, 8'd5, 8'd255, 8'd0};
    logic [N-1:0] tv_b [4] = '{8'd1,   8'd9, 8'd255, 8'd3};
    logic [N-1:0] tv_q [4] = '{8'd255, 8'd0, 8'd1,   8'd0};
    logic [N-1:0] tv_r [4] = '{8'd0,   8'd5, 8'd0,   8'd0};

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_quotient", quotient, 8'd0);
        check("reset_remainder", remainder, 8'd0);
        check("reset_dbz", div_by_zero, 1'b0);
        rst = 1'b0;
        #1 cmp_en = 1'b1;
        @(negedge clk);

        // 200 / 7
        issue(8'd200, 8'd7);
        wait_done(lat, sb);
        check("t1_latency", lat, 9);
        check("t1_quotient", quotient, 8'd28);
        check("t1_remainder", remainder, 8'd4);
        check("t1_dbz", div_by_zero, 1'b0);
        @(negedge clk);

        // Boundary operand table
        for (int i = 0; i < 4; i++) begin
            issue(tv_a[i], tv_b[i]);
            wait_done(lat, sb);
            check("t2_latency", lat, 9);
            check("t2_quotient", quotient, tv_q[i]);
            check("t2_remainder", remainder, tv_r[i]);
        end
        @(negedge clk);

        // 77 / 0
        issue(8'd77, 8'd0);
        wait_done(lat, sb);
        check("t3_latency", lat, 1);
        check("t3_quotient", quotient, 8'hFF);
        check("t3_remainder", remainder, 8'd77);
        check("t3_dbz", div_by_zero, 1'b1);
        check("t3_busy_seen", sb, 1'b0);
        @(negedge clk);

        // Start with new operands during RUN is ignored
        issue(8'd100, 8'd3);
        repeat (2) @(negedge clk);
        issue(8'd50, 8'd5);
        wait_done(lat, sb);
        check("t4_latency_rest", lat, 7);
        check("t4_quotient", quotient, 8'd33);
        check("t4_remainder", remainder, 8'd1);
        check("t4_dbz", div_by_zero, 1'b0);
        @(negedge clk);

        // Reset on the edge of iteration 4
        issue(8'd123, 8'd4);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_busy", busy, 1'b0);
        check("t5_done", done, 1'b0);
        check("t5_quotient", quotient, 8'd0);
        check("t5_remainder", remainder, 8'd0);
        n_dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) n_dones++;
        end
        check("t5_no_done", n_dones, 0);

        // Back-to-back with start held through DONE
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd6;
        @(posedge clk);
        #1;
        dividend = 8'd9;
        divisor  = 8'd2;
        wait_done(lat, sb);
        check("t6_first_latency", lat, 9);
        check("t6_first_quotient", quotient, 8'd8);
        check("t6_first_remainder", remainder, 8'd2);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, sb);
        check("t6_second_latency", lat, 9);
        check("t6_second_quotient", quotient, 8'd4);
        check("t6_second_remainder", remainder, 8'd1);
        @(negedge clk);

        // Strided operand sweep, values checked by the model
        for (int a = 0; a < 256; a += 17) begin
            for (int b = 0; b < 256; b += 5) begin
                issue(N'(a), N'(b));
                wait_done(lat, sb);
                check("sweep_latency", lat, (b == 0) ? 1 : 9);
            end
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
